controlador_posicion: RTL and testbench

//  Player-piece position controller; directly upstream of the collision Detector.
//  - Turns raw iz/der button levels and an internal gravity timer into the 16-bit

---
 rtl/controlador_posicion_if.sv | 24 ++
 rtl/controlador_posicion.sv | 156 +++++++++++++++
 tb/tb_controlador_posicion.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/controlador_posicion_if.sv
// Signal bundle between the position controller and its neighbours
// (button inputs, Detector handshake and position outputs).
interface controlador_posicion_if;
  logic        iz;
  logic        der;
  logic        GameOver;
  logic        Nuevo;
  logic [15:0] posicionActual;
  logic        movIz;
  logic        movDer;
  logic        movAbajo;
  logic        Llego;
  logic        Activo;

  modport master (
    output iz, der, GameOver, Nuevo,
    input  posicionActual, movIz, movDer, movAbajo, Llego, Activo
  );

  modport slave (
    input  iz, der, GameOver, Nuevo,
    output posicionActual, movIz, movDer, movAbajo, Llego, Activo
  );
endinterface

// File: rtl/controlador_posicion.sv
// Player-piece position controller: synchronises the buttons, applies gravity
// and produces the {x,y} position plus move strobes for the collision Detector.
module controlador_posicion #(
  parameter logic [7:0]  X_INICIO    = 8'd64,
  parameter logic [7:0]  Y_INICIO    = 8'd0,
  parameter logic [7:0]  X_MAX       = 8'd144,
  parameter logic [7:0]  Y_MAX       = 8'd224,
  parameter logic [7:0]  STEP_X      = 8'd16,
  parameter logic [7:0]  STEP_Y      = 8'd16,
  parameter logic [23:0] GRAVITY_DIV = 24'd2500000
) (
  input logic                    Clock,
  input logic                    Reset,
  controlador_posicion_if.slave  bus
);

  typedef enum logic [1:0] {
    INICIO,
    JUGANDO,
    ASENTADO,
    CONGELADO
  } estado_t;

  estado_t     estado, estado_n;

  // [0] and [1] form the synchroniser, [2] is the edge-detect history
  logic [2:0]  iz_sync, der_sync;
  logic        pulso_iz, pulso_der;

  logic [7:0]  x, x_n;
  logic [7:0]  y, y_n;
  logic [23:0] cnt, cnt_n;
  logic        mov_iz, mov_iz_n;
  logic        mov_der, mov_der_n;
  logic        mov_abajo, mov_abajo_n;
  logic        llego, llego_n;

  logic [8:0]  suma_der, suma_abajo;
  logic        tick;

  assign pulso_iz  = iz_sync[1]  & ~iz_sync[2];
  assign pulso_der = der_sync[1] & ~der_sync[2];

  assign suma_der   = {1'b0, x} + {1'b0, STEP_X};
  assign suma_abajo = {1'b0, y} + {1'b0, STEP_Y};
  assign tick       = (cnt == GRAVITY_DIV - 24'd1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      iz_sync   <= '1;
      der_sync  <= '1;
      estado    <= INICIO;
      x         <= X_INICIO;
      y         <= Y_INICIO;
      cnt       <= '0;
      mov_iz    <= 1'b0;
      mov_der   <= 1'b0;
      mov_abajo <= 1'b0;
      llego     <= 1'b0;
    end else begin
      iz_sync   <= {iz_sync[1:0], bus.iz};
      der_sync  <= {der_sync[1:0], bus.der};
      estado    <= estado_n;
      x         <= x_n;
      y         <= y_n;
      cnt       <= cnt_n;
      mov_iz    <= mov_iz_n;
      mov_der   <= mov_der_n;
      mov_abajo <= mov_abajo_n;
      llego     <= llego_n;
    end
  end

  always_comb begin
    estado_n    = estado;
    x_n         = x;
    y_n         = y;
    cnt_n       = cnt;
    mov_iz_n    = 1'b0;
    mov_der_n   = 1'b0;
    mov_abajo_n = 1'b0;
    llego_n     = llego;

    unique case (estado)
      INICIO: begin
        x_n      = X_INICIO;
        y_n      = Y_INICIO;
        cnt_n    = '0;
        llego_n  = 1'b0;
        estado_n = JUGANDO;
      end

      JUGANDO: begin
        if (bus.GameOver) begin
          estado_n = CONGELADO;
        end else begin
          // Simultaneous left and right presses cancel each other out
          if (pulso_iz && !pulso_der) begin
            if (x >= STEP_X) begin
              x_n      = x - STEP_X;
              mov_iz_n = 1'b1;
            end
          end else if (pulso_der && !pulso_iz) begin
            if (suma_der <= {1'b0, X_MAX}) begin
              x_n       = suma_der[7:0];
              mov_der_n = 1'b1;
            end
          end

          if (tick) begin
            cnt_n       = '0;
            mov_abajo_n = 1'b1;
            if (suma_abajo < {1'b0, Y_MAX}) begin
              y_n = suma_abajo[7:0];
            end else begin
              y_n      = Y_MAX;
              llego_n  = 1'b1;
              estado_n = ASENTADO;
            end
          end else begin
            cnt_n = cnt + 24'd1;
          end
        end
      end

      ASENTADO: begin
        if (bus.GameOver) begin
          estado_n = CONGELADO;
        end else if (bus.Nuevo) begin
          // Respawn position is loaded on the way into INICIO so the
          // Detector never sees the settled position while respawning
          x_n      = X_INICIO;
          y_n      = Y_INICIO;
          cnt_n    = '0;
          estado_n = INICIO;
        end
      end

      CONGELADO: begin
        estado_n = CONGELADO;
      end

      default: begin
        estado_n = INICIO;
      end
    endcase
  end

  assign bus.posicionActual = {x, y};
  assign bus.movIz          = mov_iz;
  assign bus.movDer         = mov_der;
  assign bus.movAbajo       = mov_abajo;
  assign bus.Llego          = llego;
  assign bus.Activo         = (estado == JUGANDO);

endmodule

// File: tb/tb_controlador_posicion.sv
// Table-driven bench for controlador_posicion: one record per stimulus run,
// expected outputs queued when driven and compared after the clock edge.
module tb_controlador_posicion;

  localparam int D = -1;  // don't care
  localparam int T = -2;  // y/movAbajo from the gravity timeline (DIV=8, STEP=16)

  logic Clock = 1'b0;
  logic Reset;

  always #5 Clock = ~Clock;

  controlador_posicion_if bus ();

  controlador_posicion #(
    .X_INICIO    (8'd64),
    .Y_INICIO    (8'd0),
    .X_MAX       (8'd144),
    .Y_MAX       (8'd224),
    .STEP_X      (8'd16),
    .STEP_Y      (8'd16),
    .GRAVITY_DIV (24'd8)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic rst, iz, der, go, nu;
    int   rep;
    logic chk;
    int   x, y, mi, md, ma, ll, ac;
  } vec_t;

  typedef struct {
    int id;
    int x, y, mi, md, ma, ll, ac;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   ecnt  = 0;

  function automatic void add(input logic rst, iz, der, go, nu, input int rep,
                              input logic chk, input int x, y, mi, md, ma, ll, ac);
    vec_t v;
    v.rst = rst; v.iz = iz; v.der = der; v.go = go; v.nu = nu;
    v.rep = rep; v.chk = chk;
    v.x = x; v.y = y; v.mi = mi; v.md = md; v.ma = ma; v.ll = ll; v.ac = ac;
    tbl.push_back(v);
  endfunction

  task automatic cmp(input string name, input int id, input int act, input int expv);
    if (expv >= 0) begin
      total++;
      if (act != expv) begin
        bad++;
        $display("FAIL v%0d.%s: got %0d want %0d", id, name, act, expv);
      end
    end
  endtask

  initial begin
    int xe;
    exp_t e;

    // 1: reset, spawn, gravity every 8 cycles
    add(1,0,0,0,0, 1,1, 64,0,  0,0,0, 0,0);
    add(0,0,0,0,0, 1,1, 64,T,  0,0,D, 0,1);
    add(0,0,0,0,0, 7,1, 64,0,  0,0,0, 0,1);
    add(0,0,0,0,0, 1,1, 64,16, 0,0,1, 0,1);
    add(0,0,0,0,0, 1,1, 64,16, 0,0,0, 0,1);
    add(0,0,0,0,0, 6,1, 64,16, 0,0,0, 0,1);
    add(0,0,0,0,0, 1,1, 64,32, 0,0,1, 0,1);

    // 2: six right presses (reset lands mid-count), clamp at X_MAX
    add(1,0,0,0,0, 1,1, 64,0, 0,0,0, 0,0);
    add(0,0,0,0,0, 1,1, 64,T, 0,0,D, 0,1);
    for (int p = 0; p < 6; p++) begin
      xe = (64 + 16 * (p + 1) > 144) ? 144 : 64 + 16 * (p + 1);
      add(0,0,1,0,0, 2,0, D,D, D,D,D, D,D);
      add(0,0,0,0,0, 1,1, xe,16*(p/2), 0,(p<5)?1:0,0, 0,1);
      add(0,0,0,0,0, 1,1, xe,T, 0,0,D, 0,1);
    end

    // 3: iz held through reset release does not move; left clamp at 0
    add(1,1,0,0,0, 2,1, 64,0, 0,0,0, 0,0);
    add(0,1,0,0,0, 3,1, 64,T, 0,0,D, 0,1);
    add(0,0,0,0,0, 2,1, 64,T, 0,0,D, 0,1);
    for (int p = 0; p < 5; p++) begin
      xe = (64 - 16 * (p + 1) < 0) ? 0 : 64 - 16 * (p + 1);
      add(0,1,0,0,0, 2,0, D,D, D,D,D, D,D);
      add(0,0,0,0,0, 1,1, xe,T, (p<4)?1:0,0,D, 0,1);
      add(0,0,0,0,0, 1,1, xe,T, 0,0,D, 0,1);
    end

    // 4: both buttons cancel; der update coinciding with a gravity tick
    add(1,0,0,0,0, 1,1, 64,0, 0,0,0, 0,0);
    add(0,0,0,0,0, 1,1, 64,T, 0,0,D, 0,1);
    add(0,1,1,0,0, 2,0, D,D, D,D,D, D,D);
    add(0,0,0,0,0, 1,1, 64,T, 0,0,D, 0,1);
    add(0,0,0,0,0, 1,1, 64,T, 0,0,D, 0,1);
    add(0,0,0,0,0, 1,0, D,D, D,D,D, D,D);
    add(0,0,1,0,0, 2,0, D,D, D,D,D, D,D);
    add(0,0,0,0,0, 1,1, 80,T, 0,1,D, 0,1);

    // 5: fall to the floor, ignore buttons while settled, respawn on Nuevo
    add(0,0,0,0,0, 103,1, 80,T,   0,0,D, 0,1);
    add(0,0,0,0,0, 1,1,   80,224, 0,0,1, 1,0);
    add(0,0,1,0,0, 2,1,   80,224, 0,0,0, 1,0);
    add(0,0,0,0,0, 8,1,   80,224, 0,0,0, 1,0);
    add(0,0,0,0,1, 1,1,   64,0,   0,0,0, D,0);
    add(0,0,0,0,0, 1,1,   64,0,   0,0,0, 0,1);
    add(0,0,0,0,0, 8,1,   64,T,   0,0,D, 0,1);

    // 6: GameOver on the der-update cycle freezes everything until Reset
    add(1,0,0,0,0, 1,1,  64,0, 0,0,0, 0,0);
    add(0,0,0,0,0, 1,1,  64,T, 0,0,D, 0,1);
    add(0,0,1,0,0, 2,0,  D,D,  D,D,D, D,D);
    add(0,0,0,1,0, 1,1,  64,0, 0,0,0, 0,0);
    add(0,0,0,0,0, 1,1,  64,0, 0,0,0, 0,0);
    add(0,0,1,0,0, 2,0,  D,D,  D,D,D, D,D);
    add(0,0,0,0,0, 3,0,  D,D,  D,D,D, D,D);
    add(0,0,0,0,1, 1,1,  64,0, 0,0,0, 0,0);
    add(0,0,0,0,0, 14,1, 64,0, 0,0,0, 0,0);
    add(1,0,0,0,0, 1,1,  64,0, 0,0,0, 0,0);
    add(0,0,0,0,0, 9,1,  64,T, 0,0,D, 0,1);

    Reset        = 1'b1;
    bus.iz       = 1'b0;
    bus.der      = 1'b0;
    bus.GameOver = 1'b0;
    bus.Nuevo    = 1'b0;

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        Reset        = tbl[i].rst;
        bus.iz       = tbl[i].iz;
        bus.der      = tbl[i].der;
        bus.GameOver = tbl[i].go;
        bus.Nuevo    = tbl[i].nu;
        ecnt = (tbl[i].rst || tbl[i].nu) ? 0 : ecnt + 1;
        if (tbl[i].chk && r == tbl[i].rep - 1) begin
          e.id = i;
          e.x  = tbl[i].x;  e.y  = tbl[i].y;
          e.mi = tbl[i].mi; e.md = tbl[i].md; e.ma = tbl[i].ma;
          e.ll = tbl[i].ll; e.ac = tbl[i].ac;
          if (tbl[i].y == T) begin
            e.y  = (16 * ((ecnt - 1) / 8) > 224) ? 224 : 16 * ((ecnt - 1) / 8);
            e.ma = (ecnt >= 9 && ((ecnt - 1) % 8) == 0) ? 1 : 0;
          end
          sb.push_back(e);
        end
        @(posedge Clock);
        #1;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          cmp("x",        e.id, int'(bus.posicionActual[15:8]), e.x);
          cmp("y",        e.id, int'(bus.posicionActual[7:0]),  e.y);
          cmp("movIz",    e.id, int'(bus.movIz),    e.mi);
          cmp("movDer",   e.id, int'(bus.movDer),   e.md);
          cmp("movAbajo", e.id, int'(bus.movAbajo), e.ma);
          cmp("Llego",    e.id, int'(bus.Llego),    e.ll);
          cmp("Activo",   e.id, int'(bus.Activo),   e.ac);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
